// File: rtl/nist_pkg.sv
// Shared definitions for the NIST test-stream generator: pattern modes,
// PRBS polynomial taps, default seed and the generator FSM encoding.
package nist_pkg;

  // Pattern selects
  localparam logic [2:0] MODE_ZERO = 3'd0;
  localparam logic [2:0] MODE_ONE  = 3'd1;
  localparam logic [2:0] MODE_ALT  = 3'd2;
  localparam logic [2:0] MODE_PRBS = 3'd3;
  localparam logic [2:0] MODE_RUNS = 3'd4;
  localparam logic [2:0] MODE_BIAS = 3'd5;

  // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting form: feedback taps
  localparam int unsigned LFSR_TAP_0 = 0;
  localparam int unsigned LFSR_TAP_1 = 2;
  localparam int unsigned LFSR_TAP_2 = 3;
  localparam int unsigned LFSR_TAP_3 = 5;

  // A zero seed would lock the LFSR, so it is swapped for this value
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Feedback bit entering at the MSB on each shift
  function automatic logic lfsr16_fb(input logic [15:0] s);
    return s[LFSR_TAP_0] ^ s[LFSR_TAP_1] ^ s[LFSR_TAP_2] ^ s[LFSR_TAP_3];
  endfunction

endpackage

// File: rtl/prbs_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
// Load has priority over step; the raw state is exported so other
// checkers can derive their own bits from it.
module prbs_lfsr16
  import nist_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;

  // LFSR state: seed on load, shift right with feedback into bit 15 on enable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= 16'h0000;
    end else if (i_load) begin
      r_lfsr <= i_seed;
    end else if (i_en) begin
      r_lfsr <= {lfsr16_fb(r_lfsr), r_lfsr[15:1]};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/nist_bitstream_gen.sv
// Deterministic 1-bit stream source for the NIST SP 800-22 tester.
// Emits BLOCK_LEN*N bits of a selected pattern with block markers.
// Configuration and pattern state are set up on the edge that accepts
// start, so the LOAD cycle already produces the first registered bit and
// the output stream trails the FSM by one cycle.
module nist_bitstream_gen
  import nist_pkg::*;
#(
  parameter int LFSR_W    = 16,
  parameter int BLOCK_LEN = 128,
  parameter int RUN_MAX   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [2:0]        i_mode,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [7:0]        i_nblocks,
  output logic              o_bit_out,
  output logic              o_bit_valid,
  output logic              o_block_start,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BCW = $clog2(BLOCK_LEN);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BLOCK_LEN - 1);
  localparam logic [3:0]     RUN_TOP  = 4'(RUN_MAX);

  state_e         r_state;
  state_e         w_next_state;
  logic           w_accept;
  logic           w_emit;
  logic           w_last;
  logic           w_bit;
  logic [15:0]    w_seed;
  logic [15:0]    w_lfsr;

  logic [2:0]     r_mode;
  logic [8:0]     r_nblk;
  logic [BCW-1:0] r_bit_cnt;
  logic [8:0]     r_blk_cnt;
  logic           r_alt;
  logic           r_run_val;
  logic [3:0]     r_run_len;
  logic [3:0]     r_run_cnt;

  logic           r_bit_out;
  logic           r_bit_valid;
  logic           r_block_start;
  logic           r_busy;
  logic           r_done;

  assign w_seed = (i_seed == {LFSR_W{1'b0}}) ? DEFAULT_SEED : 16'(i_seed);
  assign w_last = (r_bit_cnt == BIT_LAST) && (r_blk_cnt == (r_nblk - 9'd1));

  prbs_lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_en    (w_emit),
    .i_seed  (w_seed),
    .o_state (w_lfsr)
  );

  // Next state: emit one bit per LOAD/RUN cycle unless aborted; stop beats last bit
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_LOAD;
          w_accept     = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (i_stop) begin
          w_next_state = ST_IDLE;
        end else begin
          w_emit       = 1'b1;
          w_next_state = w_last ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Pattern bit for the current generator state
  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      MODE_ZERO: w_bit = 1'b0;
      MODE_ONE:  w_bit = 1'b1;
      MODE_ALT:  w_bit = r_alt;
      MODE_PRBS: w_bit = w_lfsr[0];
      MODE_RUNS: w_bit = r_run_val;
      MODE_BIAS: w_bit = w_lfsr[0] & w_lfsr[1];
      default:   w_bit = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch run configuration when start is accepted; 0 blocks means 256
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= 3'd0;
      r_nblk <= 9'd0;
    end else if (w_accept) begin
      r_mode <= i_mode;
      r_nblk <= (i_nblocks == 8'd0) ? 9'd256 : {1'b0, i_nblocks};
    end else begin
      r_mode <= r_mode;
      r_nblk <= r_nblk;
    end
  end

  // Bit/block counters and ALT/run-ladder state; patterns run on across blocks
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_blk_cnt <= 9'd0;
      r_alt     <= 1'b0;
      r_run_val <= 1'b0;
      r_run_len <= 4'd0;
      r_run_cnt <= 4'd0;
    end else if (w_accept) begin
      r_bit_cnt <= '0;
      r_blk_cnt <= 9'd0;
      r_alt     <= 1'b0;
      r_run_val <= 1'b0;
      r_run_len <= 4'd1;
      r_run_cnt <= 4'd0;
    end else if (w_emit) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_blk_cnt <= (r_bit_cnt == BIT_LAST) ? r_blk_cnt + 9'd1 : r_blk_cnt;
      r_alt     <= ~r_alt;
      if (r_run_cnt == (r_run_len - 4'd1)) begin
        r_run_cnt <= 4'd0;
        r_run_val <= ~r_run_val;
        r_run_len <= (r_run_len == RUN_TOP) ? 4'd1 : r_run_len + 4'd1;
      end else begin
        r_run_cnt <= r_run_cnt + 4'd1;
      end
    end else begin
      r_bit_cnt <= r_bit_cnt;
      r_blk_cnt <= r_blk_cnt;
    end
  end

  // Registered stream outputs; busy covers the whole visible stream plus its last bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_block_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_bit_out     <= w_emit & w_bit;
      r_bit_valid   <= w_emit;
      r_block_start <= w_emit && (r_bit_cnt == '0);
      r_busy        <= (w_next_state != ST_IDLE);
      r_done        <= (r_state == ST_DONE);
    end
  end

  assign o_bit_out     = r_bit_out;
  assign o_bit_valid   = r_bit_valid;
  assign o_block_start = r_block_start;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
